// File: rtl/deco_gen_pkg.sv
// Shared constants and the 8x8 font for the text pixel generator.
package deco_gen_pkg;

  localparam int MAX_X = 640;
  localparam int MAX_Y = 480;

  localparam logic [2:0] GLYPH_SPACE = 3'd0;
  localparam logic [2:0] GLYPH_C     = 3'd1;
  localparam logic [2:0] GLYPH_O     = 3'd2;
  localparam logic [2:0] GLYPH_N     = 3'd3;
  localparam logic [2:0] GLYPH_T     = 3'd4;
  localparam logic [2:0] GLYPH_R     = 3'd5;
  localparam logic [2:0] GLYPH_L     = 3'd6;
  localparam logic [2:0] GLYPH_BLOCK = 3'd7;

  // Glyphs packed row 0 in the top byte; bit 7 of each row is the leftmost pixel.
  function automatic logic [7:0] font_row(input logic [2:0] code, input logic [2:0] row);
    logic [63:0] g;
    logic [5:0]  sh;
    case (code)
      GLYPH_C:     g = 64'h3C66_6060_6066_3C00;
      GLYPH_O:     g = 64'h3C66_6666_6666_3C00;
      GLYPH_N:     g = 64'h6676_7E7E_6E66_6600;
      GLYPH_T:     g = 64'h7E18_1818_1818_1800;
      GLYPH_R:     g = 64'h7C66_667C_786C_6600;
      GLYPH_L:     g = 64'h6060_6060_6060_7E00;
      GLYPH_BLOCK: g = 64'hFFFF_FFFF_FFFF_FFFF;
      default:     g = 64'h0;
    endcase
    sh = {~row, 3'b000};
    return g[sh +: 8];
  endfunction

endpackage

// File: rtl/font_rom_8x8.sv
// Combinational 8x8 font lookup: glyph code + row -> row pixels.
module font_rom_8x8
  import deco_gen_pkg::*;
(
  input  logic [2:0] code_i,
  input  logic [2:0] row_i,
  output logic [7:0] data_o
);

  assign data_o = font_row(code_i, row_i);

endmodule

// File: rtl/deco_gen_text.sv
// Two-stage text pixel generator: movable, blinking string of scaled 8x8 glyphs.
module deco_gen_text
  import deco_gen_pkg::*;
#(
  parameter int         N_CHARS      = 4,
  parameter int         SCALE_LOG2   = 1,
  parameter int         DEF_X        = 320,
  parameter int         DEF_Y        = 240,
  parameter int         BLINK_FRAMES = 30,
  parameter logic [2:0] BLANK_RGB    = 3'b111,
  parameter logic [2:0] BG_RGB       = 3'b000
)(
  input  logic       clk,
  input  logic       reset,
  input  logic       video_on,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  input  logic [2:0] sw_rgb,
  input  logic       char_we,
  input  logic [3:0] char_idx,
  input  logic [2:0] char_code,
  input  logic       pos_we,
  input  logic [9:0] pos_x,
  input  logic [9:0] pos_y,
  input  logic       blink_en,
  output logic [2:0] graph_rgb
);

  localparam int CW    = 8 << SCALE_LOG2;
  localparam int BOX_W = N_CHARS * CW;
  localparam int CSH   = 3 + SCALE_LOG2;
  localparam int BW    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

  logic [2:0]    cell_q [N_CHARS];
  logic [9:0]    act_x_q, act_y_q, pend_x_q, pend_y_q;
  logic          pend_q;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          phase_q, phase_d;
  logic          frame_tick;

  logic [10:0]   dx, dy, cell_w;
  logic          s1_in_box_d;
  logic [2:0]    s1_code_d;
  logic [2:0]    s1_code_q, s1_row_q, s1_col_q;
  logic          s1_in_box_q, s1_von_q;

  logic [7:0]    font_data;
  logic [2:0]    bit_sel;
  logic          font_bit;
  logic [2:0]    graph_rgb_d, graph_rgb_q;

  assign frame_tick = (pix_x == 10'd0) && (pix_y == 10'(MAX_Y));

  // Text buffer; out-of-range indices match no cell and are dropped.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_CHARS; i++) begin
      if (!reset)                             cell_q[i] <= GLYPH_SPACE;
      else if (char_we && char_idx == 4'(i))  cell_q[i] <= char_code;
    end
  end

  // Position: writes are staged and only take effect on the frame tick, so a
  // frame is never drawn at two positions. A write on the tick stays pending.
  always_ff @(posedge clk) begin
    if (!reset) begin
      act_x_q  <= 10'(DEF_X);
      act_y_q  <= 10'(DEF_Y);
      pend_x_q <= 10'(DEF_X);
      pend_y_q <= 10'(DEF_Y);
      pend_q   <= 1'b0;
    end else begin
      if (frame_tick && pend_q) begin
        act_x_q <= pend_x_q;
        act_y_q <= pend_y_q;
      end
      if (pos_we) begin
        pend_x_q <= pos_x;
        pend_y_q <= pos_y;
        pend_q   <= 1'b1;
      end else if (frame_tick) begin
        pend_q   <= 1'b0;
      end
    end
  end

  // Blink next state: frame counter wraps every BLINK_FRAMES ticks and flips phase.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (!blink_en) begin
      blink_cnt_d = '0;
      phase_d     = 1'b0;
    end else if (frame_tick) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  // Blink state register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end

  // Pixel offsets are 11-bit so a pixel left/above the box wraps to a huge
  // value and falls outside the box compare; no signed logic needed.
  assign dx     = {1'b0, pix_x} - {1'b0, act_x_q};
  assign dy     = {1'b0, pix_y} - {1'b0, act_y_q};
  assign cell_w = dx >> CSH;

  // Stage 1 combinational: box test and cell code selection.
  always_comb begin
    s1_in_box_d = (dx < 11'(BOX_W)) && (dy < 11'(CW));
    s1_code_d   = GLYPH_SPACE;
    for (int i = 0; i < N_CHARS; i++)
      if (cell_w == 11'(i)) s1_code_d = cell_q[i];
  end

  // Stage 1 register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_code_q   <= GLYPH_SPACE;
      s1_row_q    <= '0;
      s1_col_q    <= '0;
      s1_in_box_q <= 1'b0;
      s1_von_q    <= 1'b0;
    end else begin
      s1_code_q   <= s1_code_d;
      s1_row_q    <= dy[SCALE_LOG2 +: 3];
      s1_col_q    <= dx[SCALE_LOG2 +: 3];
      s1_in_box_q <= s1_in_box_d;
      s1_von_q    <= video_on;
    end
  end

  font_rom_8x8 u_font (
    .code_i (s1_code_q),
    .row_i  (s1_row_q),
    .data_o (font_data)
  );

  assign bit_sel  = 3'd7 - s1_col_q;
  assign font_bit = font_data[bit_sel];

  // Stage 2 output mux; sw_rgb and blink_en are taken live here.
  always_comb begin
    graph_rgb_d = BG_RGB;
    if (!s1_von_q)
      graph_rgb_d = BLANK_RGB;
    else if (s1_in_box_q && font_bit && !(blink_en && phase_q))
      graph_rgb_d = sw_rgb;
  end

  // Stage 2 register.
  always_ff @(posedge clk) begin
    if (!reset) graph_rgb_q <= BLANK_RGB;
    else        graph_rgb_q <= graph_rgb_d;
  end

  assign graph_rgb = graph_rgb_q;

endmodule

// File: tb/tb_deco_gen_text.sv
// Randomized scoreboard bench for deco_gen_text against a pixel-level model.
module tb_deco_gen_text;

  localparam int N  = 4;
  localparam int S  = 1;
  localparam int DX = 320;
  localparam int DY = 240;
  localparam int BF = 2;
  localparam int CW = 8 * (2 ** S);
  localparam logic [2:0] BLANK = 3'b111;
  localparam logic [2:0] BG    = 3'b000;

  // Glyph bitmaps, row 0 in the top byte, leftmost pixel in the MSB.
  localparam logic [63:0] FONT [8] = '{
    64'h0000000000000000, 64'h3C66606060663C00, 64'h3C66666666663C00,
    64'h66767E7E6E666600, 64'h7E18181818181800, 64'h7C66667C786C6600,
    64'h6060606060607E00, 64'hFFFFFFFFFFFFFFFF };

  logic clk = 0, reset = 0, video_on = 0, char_we = 0, pos_we = 0, blink_en = 0;
  logic [9:0] pix_x = 0, pix_y = 0, pos_x = 0, pos_y = 0;
  logic [2:0] sw_rgb = 0, char_code = 0, graph_rgb;
  logic [3:0] char_idx = 0;

  deco_gen_text #(
    .N_CHARS(N), .SCALE_LOG2(S), .DEF_X(DX), .DEF_Y(DY),
    .BLINK_FRAMES(BF), .BLANK_RGB(BLANK), .BG_RGB(BG)
  ) dut (
    .clk(clk), .reset(reset), .video_on(video_on), .pix_x(pix_x), .pix_y(pix_y),
    .sw_rgb(sw_rgb), .char_we(char_we), .char_idx(char_idx), .char_code(char_code),
    .pos_we(pos_we), .pos_x(pos_x), .pos_y(pos_y), .blink_en(blink_en),
    .graph_rgb(graph_rgb)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0, failures = 0;

  // Reference state, updated once per clock edge.
  int cells [16];
  int ax, ay, px, py, bcnt;
  bit pend, phase;

  typedef struct { int tgt; logic [2:0] rgb; int x; int y; } exp_t;
  typedef struct { bit von; bit fg; int x; int y; } snap_t;
  exp_t  expq [$];
  snap_t prev;
  bit    have_prev = 0;

  function automatic bit glyph_px(input int x, input int y);
    int dxp, dyp, code, row, col;
    logic [63:0] g;
    dxp = x - ax; dyp = y - ay;
    if (dxp < 0 || dxp >= N * CW || dyp < 0 || dyp >= CW) return 1'b0;
    code = cells[dxp / CW];
    col  = (dxp % CW) / (CW / 8);
    row  = dyp / (CW / 8);
    g    = FONT[code];
    return g[63 - 8 * row - col];
  endfunction

  task automatic model_reset();
    foreach (cells[i]) cells[i] = 0;
    ax = DX; ay = DY; px = DX; py = DY; pend = 0; bcnt = 0; phase = 0;
  endtask

  task automatic model_edge();
    bit tick;
    tick = (pix_x == 0 && pix_y == 480);
    if (char_we && char_idx < N) cells[char_idx] = char_code;
    if (tick && pend) begin ax = px; ay = py; pend = 0; end
    if (pos_we) begin px = pos_x; py = pos_y; pend = 1; end
    if (!blink_en) begin bcnt = 0; phase = 0; end
    else if (tick) begin
      bcnt++;
      if (bcnt == BF) begin bcnt = 0; phase = !phase; end
    end
  endtask

  // One clock: settle the previous pixel's expected colour (it depends on
  // sw_rgb/blink in the following cycle), snapshot this pixel, advance model.
  task automatic step();
    snap_t s;
    if (have_prev) begin
      exp_t e;
      e.tgt = cyc + 1; e.x = prev.x; e.y = prev.y;
      if (!reset || !prev.von)                  e.rgb = BLANK;
      else if (prev.fg && !(blink_en && phase)) e.rgb = sw_rgb;
      else                                      e.rgb = BG;
      expq.push_back(e);
    end
    s.x = pix_x; s.y = pix_y;
    if (!reset) begin
      s.von = 0; s.fg = 0;
      model_reset();
    end else begin
      s.von = video_on; s.fg = glyph_px(pix_x, pix_y);
      model_edge();
    end
    prev = s; have_prev = 1;
    @(posedge clk); #1;
    char_we = 0; pos_we = 0;
  endtask

  task automatic pix(input int x, input int y);
    pix_x = 10'(x); pix_y = 10'(y);
    video_on = ($urandom_range(7) != 0);
    sw_rgb = 3'($urandom);
    if (!char_we && $urandom_range(63) == 0) begin
      char_we = 1; char_idx = 4'($urandom); char_code = 3'($urandom);
    end
    step();
  endtask

  task automatic rnd_pix();
    pix($urandom_range(639), $urandom_range(479));
  endtask

  task automatic wr(input int idx, input int code);
    char_we = 1; char_idx = 4'(idx); char_code = 3'(code);
    rnd_pix();
  endtask

  task automatic pos_write(input int wx, input int wy);
    pos_we = 1; pos_x = 10'(wx); pos_y = 10'(wy);
    rnd_pix();
  endtask

  task automatic scan_rect(input int x0, input int y0, input int w, input int h);
    for (int y = y0; y < y0 + h; y++)
      for (int x = x0; x < x0 + w; x++)
        if (x >= 0 && x < 640 && y >= 0 && y < 480) pix(x, y);
  endtask

  task automatic scan();
    scan_rect(ax - 4, ay - 2, N * CW + 8, CW + 4);
  endtask

  task automatic tick(input bit pw = 0, input int wx = 0, input int wy = 0);
    pix_x = 10'd0; pix_y = 10'd480; video_on = 0; sw_rgb = 3'($urandom);
    if (pw) begin pos_we = 1; pos_x = 10'(wx); pos_y = 10'(wy); end
    step();
  endtask

  task automatic rand_cycle();
    int r, x, y;
    r = $urandom_range(999);
    if ($urandom_range(99) == 0) blink_en = !blink_en;
    reset = ($urandom_range(599) != 0);
    if (r < 6) tick(r[0], $urandom_range(639), $urandom_range(479));
    else begin
      if (r < 12) begin pos_we = 1; pos_x = 10'($urandom_range(639)); pos_y = 10'($urandom_range(479)); end
      x = ax - 4 + $urandom_range(N * CW + 8);
      y = ay - 2 + $urandom_range(CW + 4);
      if (r[1] || x < 0 || x > 639) x = $urandom_range(639);
      if (y < 0 || y > 479) y = $urandom_range(479);
      pix(x, y);
    end
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clk) begin
    while (expq.size() > 0 && expq[0].tgt < cyc) begin
      checks++; failures++;
      $display("FAIL stale expectation tgt=%0d cyc=%0d", expq[0].tgt, cyc);
      void'(expq.pop_front());
    end
    if (expq.size() > 0 && expq[0].tgt == cyc) begin
      checks++;
      if (graph_rgb !== expq[0].rgb) begin
        failures++;
        $display("FAIL pixel(%0d,%0d) cyc=%0d got=%b expected=%b",
                 expq[0].x, expq[0].y, cyc, graph_rgb, expq[0].rgb);
      end
      void'(expq.pop_front());
    end
  end

  initial begin
    model_reset();
    reset = 0;
    repeat (3) rnd_pix();
    reset = 1;
    wr(0, 1); wr(1, 2); wr(2, 3); wr(3, 4);
    wr(4, 7); wr(15, 5);
    scan(); tick();
    // Position write mid-frame, then two writes before a tick.
    scan(); pos_write(100, 50); scan(); tick(); scan(); tick();
    pos_write(200, 100); pos_write(150, 60); tick(); scan(); tick();
    // Write coinciding with the tick stays pending for one more frame.
    pos_write(300, 200); tick(1, 400, 300); scan(); tick(); scan(); tick();
    // Blink on for several frames, then off.
    blink_en = 1;
    repeat (6) begin scan(); tick(); end
    blink_en = 0;
    scan(); tick(); scan();
    // Off-edge placements: clipped, no wrap.
    pos_write(630, 300); tick(); scan(); scan_rect(0, 300, 16, CW); tick();
    pos_write(10, 470); tick(); scan(); scan_rect(10, 0, 32, 4); tick();
    // Mid-frame reset.
    scan_rect(ax, ay, 20, 2);
    reset = 0; repeat (2) rnd_pix(); reset = 1;
    wr(0, 7); wr(1, 5); wr(2, 6); wr(3, 1);
    scan(); tick();
    repeat (3000) rand_cycle();
    reset = 1; video_on = 0;
    repeat (4) begin pix_x = 10'd5; pix_y = 10'd5; step(); end
    for (int i = 0; i < 20 && expq.size() > 0; i++) @(negedge clk);
    if (expq.size() > 0) begin
      checks++; failures++;
      $display("FAIL drain pending=%0d expected=0", expq.size());
    end
    @(posedge clk); #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
